line_cmd_scheduler: RTL and testbench
=====================================

// Module: line_cmd_scheduler
// PURPOSE
//  Avalon-MM slave command queue and sequencer for the line drawer core. Nios writes line
//  jobs (endpoints + colour) into a FIFO; the block launches them one at a time into the
//  drawer over a start/done handshake, so software never polls mid-line. Sits between the
//  Nios data master and line_drawer core; VGA side untouched.
// PARAMETERS
//  X_W      9    x coordinate width (320 px)
//  Y_W      8    y coordinate width (240 px)
//  COL_W    3    colour width
//  DEPTH    8    command FIFO entries (power of 2, >=2)
//  CNT_W    16   completed-line counter width
// PORTS
//  clk           in   1        system clock
//  reset         in   1        asynchronous active-high reset
//  avs_address   in   3        register select
//  avs_write     in   1        write strobe
//  avs_writedata in   32       write data
//  avs_read      in   1        read strobe
//  avs_readdata  out  32       read data, valid 1 cycle after avs_read (readLatency=1)
//  drw_start     out  1        one-cycle launch pulse to drawer
//  drw_x0/drw_x1 out  X_W      endpoints x, held stable from drw_start until drw_done
//  drw_y0/drw_y1 out  Y_W      endpoints y, held likewise
//  drw_colour    out  COL_W    pixel colour, held likewise
//  drw_done      in   1        one-cycle pulse from drawer: line finished
//  irq           out  1        level: queue empty and idle, gated by IRQ_EN
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM IDLE, staging regs 0, counter 0, flags 0.
//  Registers (write): 0 CTRL bit0=flush FIFO, bit1=clear OVF, bit2=IRQ_EN (stored);
//   1 START wd[X_W-1:0]=x0, wd[16+Y_W-1:16]=y0; 2 END same for x1,y1; 3 COLOUR wd[COL_W-1:0];
//   4 GO any data: push {staging} into FIFO. Staging regs persist after GO.
//  Registers (read): 0 STATUS bit0 busy (FSM!=IDLE), bit1 full, bit2 OVF, bit3 empty,
//   bit4 IRQ_EN, [15:8] FIFO count; 5 COUNT zero-ext completed lines; others read 0.
//  FIFO: push on GO when not full. GO while full: dropped, OVF set (sticky until CTRL bit1).
//   Full evaluated before same-cycle pop: GO on full is dropped even if pop occurs.
//   Push to empty FIFO in IDLE: entry visible to FSM next cycle.
//  FSM IDLE: if FIFO non-empty -> pop head into drw_* regs, go LAUNCH.
//      LAUNCH: drw_start=1 for exactly this cycle -> WAIT.
//      WAIT: hold drw_* ; on drw_done -> COUNT+=1 (wraps at 2^CNT_W), -> IDLE.
//   Min spacing between drw_start pulses: 3 cycles. drw_done outside WAIT ignored.
//  Flush: clears FIFO entries + OVF unaffected; in-flight line completes normally.
//   Flush and GO same cycle: flush wins, GO entry discarded, OVF not set.
//  irq = IRQ_EN & empty & FSM==IDLE, registered (1-cycle lag).
//  Reset mid-line: immediate return to IDLE, drw_start 0; drawer is reset by same net.
// TESTING
//  Write START x0=10,y0=20, END x1=100,y1=50, COLOUR 5, GO -> drw_start pulse 2-3 cycles
//   later, drw_x0=10 y0=20 x1=100 y1=50 colour=5 held until drw_done; COUNT reads 1.
//  Queue 3 GOs with drawer model done after 40 cycles -> 3 starts in order, never overlapping,
//   STATUS busy 1 throughout, COUNT=3, empty=1 afterwards.
//  9 GOs with drawer stalled (DEPTH=8) -> 1 in flight + 8 queued? no: 1 popped, 8 queued,
//   9th accepted; 10th GO sets OVF=1, count stays 8; CTRL bit1 clears OVF.
//  Flush while WAIT with 4 queued -> count 0 immediately, current drw_* held, one more done,
//   no further drw_start.
//  IRQ_EN=1, single line -> irq 0 while busy, rises 1 cycle after return to IDLE with empty FIFO.
//  Assert reset during WAIT -> all outputs 0 next edge-free (async), COUNT=0, FIFO empty.

Source files
------------

// File: rtl/line_cmd_scheduler.sv
// Avalon-MM command queue that feeds line jobs to the line drawer one at a time
// over a start/done handshake, with a completed-line counter and an idle interrupt.
module line_cmd_scheduler #(
    parameter int X_W   = 9,
    parameter int Y_W   = 8,
    parameter int COL_W = 3,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       avs_address,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    input  logic             avs_read,
    output logic [31:0]      avs_readdata,
    output logic             drw_start,
    output logic [X_W-1:0]   drw_x0,
    output logic [Y_W-1:0]   drw_y0,
    output logic [X_W-1:0]   drw_x1,
    output logic [Y_W-1:0]   drw_y1,
    output logic [COL_W-1:0] drw_colour,
    input  logic             drw_done,
    output logic             irq
);

    localparam int A_W = $clog2(DEPTH);
    localparam int E_W = 2 * X_W + 2 * Y_W + COL_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    logic [X_W-1:0]   x0_reg, x1_reg;
    logic [Y_W-1:0]   y0_reg, y1_reg;
    logic [COL_W-1:0] col_reg;

    logic [E_W-1:0]   fifo_mem [DEPTH];
    logic [A_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [A_W:0]     count_reg;
    logic             ovf_reg, irq_en_reg;
    state_t           state_reg;
    logic [CNT_W-1:0] line_cnt_reg;

    logic             wr_ctrl, flush, go, full, empty, push, pop;
    logic [E_W-1:0]   head;
    logic [7:0]       fifo_cnt8;
    logic             unused_wd;

    assign wr_ctrl   = avs_write && (avs_address == 3'd0);
    assign flush     = wr_ctrl && avs_writedata[0];
    assign go        = avs_write && (avs_address == 3'd4);
    assign full      = (count_reg == (A_W+1)'(DEPTH));
    assign empty     = (count_reg == '0);
    // Fullness is judged before any same-cycle pop; a flush swallows both push and pop.
    assign push      = go && !full && !flush;
    assign pop       = (state_reg == IDLE) && !empty && !flush;
    assign head      = fifo_mem[rd_ptr_reg];
    assign fifo_cnt8 = 8'(count_reg);
    assign unused_wd = ^avs_writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x0_reg     <= '0;
            y0_reg     <= '0;
            x1_reg     <= '0;
            y1_reg     <= '0;
            col_reg    <= '0;
            irq_en_reg <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            if (avs_write && avs_address == 3'd1) begin
                x0_reg <= avs_writedata[X_W-1:0];
                y0_reg <= avs_writedata[16 +: Y_W];
            end
            if (avs_write && avs_address == 3'd2) begin
                x1_reg <= avs_writedata[X_W-1:0];
                y1_reg <= avs_writedata[16 +: Y_W];
            end
            if (avs_write && avs_address == 3'd3)
                col_reg <= avs_writedata[COL_W-1:0];
            if (wr_ctrl)
                irq_en_reg <= avs_writedata[2];
            if (wr_ctrl && avs_writedata[1])
                ovf_reg <= 1'b0;
            else if (go && full && !flush)
                ovf_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {x0_reg, y0_reg, x1_reg, y1_reg, col_reg};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + A_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + A_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (A_W+1)'(1);
                2'b01:   count_reg <= count_reg - (A_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // The drw_* registers act as the registered read port of the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            drw_start    <= 1'b0;
            drw_x0       <= '0;
            drw_y0       <= '0;
            drw_x1       <= '0;
            drw_y1       <= '0;
            drw_colour   <= '0;
            line_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    drw_start <= 1'b0;
                    if (pop) begin
                        {drw_x0, drw_y0, drw_x1, drw_y1, drw_colour} <= head;
                        drw_start <= 1'b1;
                        state_reg <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    drw_start <= 1'b0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    drw_start <= 1'b0;
                    if (drw_done) begin
                        line_cnt_reg <= line_cnt_reg + CNT_W'(1);
                        state_reg    <= IDLE;
                    end
                end
                default: begin
                    drw_start <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq          <= 1'b0;
            avs_readdata <= '0;
        end else begin
            irq <= irq_en_reg && empty && (state_reg == IDLE);
            if (avs_read) begin
                case (avs_address)
                    3'd0:    avs_readdata <= {16'd0, fifo_cnt8, 3'd0, irq_en_reg,
                                              empty, ovf_reg, full, state_reg != IDLE};
                    3'd5:    avs_readdata <= 32'(line_cnt_reg);
                    default: avs_readdata <= '0;
                endcase
            end else begin
                avs_readdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_line_cmd_scheduler.sv
// Bench for line_cmd_scheduler: directed scenarios plus randomized jobs, checked
// against a job-queue model and a behavioural drawer that answers drw_start.
module tb_line_cmd_scheduler;

    localparam int X_W   = 9;
    localparam int Y_W   = 8;
    localparam int COL_W = 3;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    typedef logic [2*X_W+2*Y_W+COL_W-1:0] job_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [2:0]       avs_address = '0;
    logic             avs_write = 1'b0;
    logic [31:0]      avs_writedata = '0;
    logic             avs_read = 1'b0;
    logic [31:0]      avs_readdata;
    logic             drw_start;
    logic [X_W-1:0]   drw_x0, drw_x1;
    logic [Y_W-1:0]   drw_y0, drw_y1;
    logic [COL_W-1:0] drw_colour;
    logic             drw_done;
    logic             drw_done_m = 1'b0;
    logic             drw_done_s = 1'b0;
    logic             irq;

    assign drw_done = drw_done_m | drw_done_s;

    always #5 clk = ~clk;

    line_cmd_scheduler #(
        .X_W(X_W), .Y_W(Y_W), .COL_W(COL_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_read(avs_read), .avs_readdata(avs_readdata),
        .drw_start(drw_start), .drw_x0(drw_x0), .drw_y0(drw_y0), .drw_x1(drw_x1),
        .drw_y1(drw_y1), .drw_colour(drw_colour), .drw_done(drw_done), .irq(irq)
    );

    int   checks = 0;
    int   failures = 0;
    job_t model_q[$];
    int   lines_done = 0;
    bit   inflight = 1'b0;
    bit   stall = 1'b0;
    bit   rand_dly = 1'b0;
    int   dly = 4;
    bit   exp_ovf = 1'b0;
    bit   irq_en_m = 1'b0;

    logic [X_W-1:0]   st_x0 = '0, st_x1 = '0;
    logic [Y_W-1:0]   st_y0 = '0, st_y1 = '0;
    logic [COL_W-1:0] st_col = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic job_t cur_obs();
        return {drw_x0, drw_y0, drw_x1, drw_y1, drw_colour};
    endfunction

    function automatic logic [31:0] status_exp();
        logic [31:0] s;
        s = '0;
        s[0]    = inflight;
        s[1]    = (model_q.size() == DEPTH);
        s[2]    = exp_ovf;
        s[3]    = (model_q.size() == 0);
        s[4]    = irq_en_m;
        s[15:8] = 8'(model_q.size());
        return s;
    endfunction

    // Behavioural drawer: checks each launch against the queue model, holds for a delay, answers done.
    job_t mon_exp, mon_cur;
    int   mon_n, mon_lim;
    always begin
        @(negedge clk);
        if (!reset && drw_start) begin
            mon_cur = cur_obs();
            chk("start_expected", 64'(model_q.size() != 0), 64'd1);
            if (model_q.size() != 0) begin
                mon_exp = model_q.pop_front();
                chk("launch_job", mon_cur, mon_exp);
            end
            $display("start x0=%0d y0=%0d x1=%0d y1=%0d col=%0d", drw_x0, drw_y0, drw_x1, drw_y1, drw_colour);
            inflight = 1'b1;
            mon_lim = rand_dly ? int'($urandom_range(1, 8)) : dly;
            @(negedge clk);
            chk("start_pulse_width", drw_start, 1'b0);
            mon_n = 0;
            while ((mon_n < mon_lim || stall) && !reset) begin
                chk("hold_fields", cur_obs(), mon_cur);
                chk("no_restart", drw_start, 1'b0);
                @(negedge clk);
                mon_n++;
            end
            if (!reset) begin
                drw_done_m = 1'b1;
                @(negedge clk);
                drw_done_m = 1'b0;
                lines_done++;
            end
            inflight = 1'b0;
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs_address = a;
        avs_writedata = d;
        avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
        $display("write addr=%0d data=0x%08h", a, d);
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
        $display("read addr=%0d data=0x%08h", a, d);
    endtask

    task automatic set_start(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        logic [31:0] wd;
        wd = $urandom;
        wd[X_W-1:0] = x;
        wd[16 +: Y_W] = y;
        st_x0 = x;
        st_y0 = y;
        wr(3'd1, wd);
    endtask

    task automatic set_end(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        logic [31:0] wd;
        wd = $urandom;
        wd[X_W-1:0] = x;
        wd[16 +: Y_W] = y;
        st_x1 = x;
        st_y1 = y;
        wr(3'd2, wd);
    endtask

    task automatic set_col(input logic [COL_W-1:0] c);
        logic [31:0] wd;
        wd = $urandom;
        wd[COL_W-1:0] = c;
        st_col = c;
        wr(3'd3, wd);
    endtask

    task automatic go();
        if (model_q.size() < DEPTH)
            model_q.push_back({st_x0, st_y0, st_x1, st_y1, st_col});
        else
            exp_ovf = 1'b1;
        wr(3'd4, $urandom);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            if (model_q.size() == 0 && !inflight) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("drain_timeout", ok, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;
        bit seen;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_drw_start", drw_start, 1'b0);
        chk("rst_drw_fields", cur_obs(), '0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_readdata", avs_readdata, 32'd0);
        rd(3'd0, d);
        chk("rst_status", d, status_exp());
        rd(3'd5, d);
        chk("rst_count", d, 32'd0);

        // Single line with the canonical endpoints
        dly = 4;
        set_start(9'd10, 8'd20);
        set_end(9'd100, 8'd50);
        set_col(3'd5);
        rd(3'd1, d);
        chk("rd_addr1_zero", d, 32'd0);
        go();
        @(negedge clk);
        chk("first_start_latency", drw_start, 1'b1);
        chk("first_fields", cur_obs(), {9'd10, 8'd20, 9'd100, 8'd50, 3'd5});
        wait_idle();
        rd(3'd5, d);
        chk("count_after_one", d, 32'(lines_done));

        // Three queued lines with a slow drawer
        dly = 40;
        set_col(3'd1); go();
        set_col(3'd2); go();
        set_start(9'd319, 8'd239); go();
        repeat (15) @(negedge clk);
        rd(3'd0, d);
        chk("busy_mid_queue", d[0], 1'b1);
        wait_idle();
        rd(3'd5, d);
        chk("count_after_three", d, 32'(lines_done));
        rd(3'd0, d);
        chk("status_after_three", d, status_exp());

        // Stalled drawer: fill queue, overflow, clear OVF, then flush
        stall = 1'b1;
        dly = 2;
        for (int i = 0; i < 10; i++) begin
            set_col(3'(i));
            go();
        end
        rd(3'd0, d);
        chk("status_overflow", d, status_exp());
        wr(3'd0, 32'h2);
        exp_ovf = 1'b0;
        rd(3'd0, d);
        chk("status_ovf_cleared", d, status_exp());
        wr(3'd0, 32'h1);
        model_q.delete();
        rd(3'd0, d);
        chk("status_flushed", d, status_exp());
        stall = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);
        rd(3'd5, d);
        chk("count_after_flush", d, 32'(lines_done));

        // Interrupt behaviour around one line
        wr(3'd0, 32'h4);
        irq_en_m = 1'b1;
        repeat (2) @(negedge clk);
        chk("irq_idle", irq, 1'b1);
        dly = 10;
        go();
        repeat (5) @(negedge clk);
        chk("irq_busy", irq, 1'b0);
        seen = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            if (drw_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("irq_done_seen", seen, 1'b1);
        @(negedge clk);
        chk("irq_lag", irq, 1'b0);
        @(negedge clk);
        chk("irq_rise", irq, 1'b1);
        wait_idle();

        // drw_done while idle must not count
        drw_done_s = 1'b1;
        @(negedge clk);
        drw_done_s = 1'b0;
        @(negedge clk);
        rd(3'd5, d);
        chk("spurious_done_ignored", d, 32'(lines_done));

        // Randomized jobs, never enough outstanding to overflow
        wr(3'd0, 32'h0);
        irq_en_m = 1'b0;
        rand_dly = 1'b1;
        for (int j = 0; j < 40; j++) begin
            if ($urandom_range(0, 1) == 1)
                set_start(9'($urandom_range(0, 319)), 8'($urandom_range(0, 239)));
            if ($urandom_range(0, 1) == 1)
                set_end(9'($urandom_range(0, 319)), 8'($urandom_range(0, 239)));
            if ($urandom_range(0, 2) == 0)
                set_col(3'($urandom));
            seen = 1'b0;
            for (int t = 0; t < 500; t++) begin
                if (model_q.size() + 1 < DEPTH) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!seen)
                chk("random_room_timeout", seen, 1'b1);
            go();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();
        rd(3'd5, d);
        chk("count_random", d, 32'(lines_done));
        rd(3'd0, d);
        chk("status_random", d, status_exp());
        rand_dly = 1'b0;

        // Asynchronous reset in the middle of a line
        stall = 1'b1;
        go(); go(); go();
        seen = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (inflight) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("reset_line_started", seen, 1'b1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_start", drw_start, 1'b0);
        chk("async_rst_fields", cur_obs(), '0);
        chk("async_rst_irq", irq, 1'b0);
        model_q.delete();
        exp_ovf = 1'b0;
        irq_en_m = 1'b0;
        lines_done = 0;
        stall = 1'b0;
        st_x0 = '0; st_y0 = '0; st_x1 = '0; st_y1 = '0; st_col = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        rd(3'd5, d);
        chk("count_after_reset", d, 32'd0);
        rd(3'd0, d);
        chk("status_after_reset", d, status_exp());
        dly = 3;
        go();
        wait_idle();
        rd(3'd5, d);
        chk("count_restart", d, 32'(lines_done));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
